lcd_cmd_scheduler: RTL and testbench

Sits between the game control FSM and LCDDriver4Bit. It queues character-advance writes (wEn/charNum) and full line refreshes (wLineEn/lineIn/nextLineIn), issues them as one-cycle pulses, and enforces a minimum gap after each command so the driver finishes its LCD transfer before the next one. A line refresh always has priority over character writes and supersedes any that are still queued.

---
 rtl/lcd_cmd_scheduler_if.sv | 35 +++
 rtl/lcd_cmd_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_lcd_cmd_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_scheduler_if.sv
// Request/command bundle between the game control FSM and lcd_cmd_scheduler.
// Latency: none, wires only.
// Backpressure: none; the scheduler queues or drops requests and reports overflow.
interface lcd_cmd_scheduler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;

    // Requests from the control FSM
    logic          charReq;
    logic [3:0]    charIdx;
    logic          lineReq;
    logic [63:0]   lineIn;
    logic [63:0]   nextLineIn;

    // Commands toward LCDDriver4Bit and status
    logic          wEn;
    logic          wLineEn;
    logic [3:0]    charNum;
    logic [63:0]   lineOut;
    logic [63:0]   nextLineOut;
    logic          busy;
    logic          overflow;
    logic [PW-1:0] pending;

    modport master (
        output charReq, charIdx, lineReq, lineIn, nextLineIn,
        input  wEn, wLineEn, charNum, lineOut, nextLineOut, busy, overflow, pending
    );

    modport slave (
        input  charReq, charIdx, lineReq, lineIn, nextLineIn,
        output wEn, wLineEn, charNum, lineOut, nextLineOut, busy, overflow, pending
    );
endinterface

// File: rtl/lcd_cmd_scheduler.sv
// Queues char writes and line refreshes for the LCD driver, issuing one-cycle pulses spaced by a gap.
// Latency: request at edge k in idle -> pulse in the cycle after edge k+1; back-to-back spacing GAP+1.
// Backpressure: none upstream; full char queue drops the request and sets sticky overflow.
// Optional: define LCD_SCHED_COALESCE_EN to absorb char requests matching an already queued index.
module lcd_cmd_scheduler #(
    parameter int CHAR_GAP   = 2000,
    parameter int LINE_GAP   = 40000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_cmd_scheduler_if.slave    bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PW   = AW + 1;
    localparam int MAXG = (CHAR_GAP > LINE_GAP) ? CHAR_GAP : LINE_GAP;
    localparam int CW   = $clog2(MAXG + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_LINE = 2'd1,
        ISSUE_CHAR = 2'd2,
        WAIT       = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    mem_q [FIFO_DEPTH];
    logic          line_pend_q;
    logic [63:0]   shadow_top_q, shadow_bot_q;
    logic [63:0]   line_out_q, next_line_out_q;
    logic [3:0]    char_num_q;
    logic          overflow_q;

    logic [PW-1:0] occ;
    logic          empty, full;
    logic          dup;
    logic          push, drop, pop, load_line;

    // Occupancy uses the extra pointer bit so a full queue differs from an empty one
    assign occ   = wr_ptr_q - rd_ptr_q;
    assign empty = (occ == '0);
    assign full  = (occ == PW'(FIFO_DEPTH));

`ifdef LCD_SCHED_COALESCE_EN
    // Flag a char request whose index already sits in a live queue slot
    always_comb begin
        logic [AW-1:0] slot;
        dup  = 1'b0;
        slot = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot = rd_ptr_q[AW-1:0] + AW'(i);
            if ((PW'(i) < occ) && (mem_q[slot] == bus.charIdx)) begin
                dup = 1'b1;
            end
        end
    end
`else
    // Without coalescing every request competes for a queue slot
    always_comb begin
        dup = 1'b0;
    end
`endif

    // A line request wins the edge: the simultaneous char request is discarded
    assign push = bus.charReq & ~bus.lineReq & ~full & ~dup;
    assign drop = bus.charReq & ~bus.lineReq &  full & ~dup;

    // Next-state and gap counter; pop/load happen on the edge that enters an issue state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        load_line = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_pend_q) begin
                    state_d   = ISSUE_LINE;
                    load_line = 1'b1;
                    cnt_d     = CW'(LINE_GAP - 1);
                end else if (!empty) begin
                    state_d = ISSUE_CHAR;
                    pop     = 1'b1;
                    cnt_d   = CW'(CHAR_GAP - 1);
                end
            end
            ISSUE_LINE, ISSUE_CHAR: begin
                // A gap of one needs no wait cycles beyond the idle cycle
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointers, shadow lines and output holding registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            line_pend_q     <= 1'b0;
            shadow_top_q    <= '0;
            shadow_bot_q    <= '0;
            line_out_q      <= '0;
            next_line_out_q <= '0;
            char_num_q      <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (pop) begin
                char_num_q <= mem_q[rd_ptr_q[AW-1:0]];
            end

            // Line request flushes whatever chars remain; a pop on the same edge still issues
            if (bus.lineReq) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end

            if (load_line) begin
                line_out_q      <= shadow_top_q;
                next_line_out_q <= shadow_bot_q;
            end

            // A newer line request overwrites the shadow and keeps a refresh pending
            if (bus.lineReq) begin
                shadow_top_q <= bus.lineIn;
                shadow_bot_q <= bus.nextLineIn;
                line_pend_q  <= 1'b1;
            end else if (load_line) begin
                line_pend_q  <= 1'b0;
            end
        end
    end

    // Queue storage needs no reset; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.charIdx;
        end
    end

    assign bus.wEn         = (state_q == ISSUE_CHAR);
    assign bus.wLineEn     = (state_q == ISSUE_LINE);
    assign bus.charNum     = char_num_q;
    assign bus.lineOut     = line_out_q;
    assign bus.nextLineOut = next_line_out_q;
    assign bus.overflow    = overflow_q;
    assign bus.pending     = occ;
    assign bus.busy        = (state_q != IDLE) | line_pend_q | ~empty;

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Scoreboard bench for lcd_cmd_scheduler with CHAR_GAP=4, LINE_GAP=8, FIFO_DEPTH=4.
// Latency: stimulus queues expected pulses; a negedge monitor pops and checks each pulse.
// Backpressure: none; directed checks cover occupancy, overflow, busy and reset behaviour.
module tb_lcd_cmd_scheduler;
    localparam int CHAR_GAP   = 4;
    localparam int LINE_GAP   = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        bit          is_line;
        logic [3:0]  idx;
        logic [63:0] top;
        logic [63:0] bot;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    bit   mon_en;

    exp_t exp_q[$];
    exp_t e_mon;
    int   pcyc[$];
    bit   last_vld;
    int   last_cyc;
    int   last_gap;

    lcd_cmd_scheduler_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    lcd_cmd_scheduler #(
        .CHAR_GAP   (CHAR_GAP),
        .LINE_GAP   (LINE_GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_char(input logic [3:0] i);
        exp_t e;
        e.is_line = 1'b0;
        e.idx     = i;
        e.top     = '0;
        e.bot     = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_line(input logic [63:0] t, input logic [63:0] b);
        exp_t e;
        e.is_line = 1'b1;
        e.idx     = '0;
        e.top     = t;
        e.bot     = b;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", bus.busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wEn"},         bus.wEn, 0);
        chk({tag, "_wLineEn"},     bus.wLineEn, 0);
        chk({tag, "_charNum"},     bus.charNum, 0);
        chk({tag, "_lineOut"},     bus.lineOut, 0);
        chk({tag, "_nextLineOut"}, bus.nextLineOut, 0);
        chk({tag, "_busy"},        bus.busy, 0);
        chk({tag, "_overflow"},    bus.overflow, 0);
        chk({tag, "_pending"},     bus.pending, 0);
    endtask

    // Monitor: every pulse must match the head of the scoreboard and respect the gap
    always @(negedge clk) begin
        if (mon_en && (bus.wEn || bus.wLineEn)) begin
            chk("pulse_excl", bus.wEn & bus.wLineEn, 0);
            chk("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                chk("pulse_kind", bus.wLineEn, e_mon.is_line);
                if (e_mon.is_line) begin
                    chk("lineOut", bus.lineOut, e_mon.top);
                    chk("nextLineOut", bus.nextLineOut, e_mon.bot);
                end else begin
                    chk("charNum", bus.charNum, e_mon.idx);
                end
            end
            if (last_vld) begin
                chk("gap_min", (cyc - last_cyc) >= (last_gap + 1), 1);
            end
            last_vld = 1'b1;
            last_cyc = cyc;
            last_gap = bus.wLineEn ? LINE_GAP : CHAR_GAP;
            pcyc.push_back(cyc);
        end
        if (reset) last_vld = 1'b0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        mon_en         = 1'b0;
        last_vld       = 1'b0;
        last_cyc       = 0;
        last_gap       = 0;
        reset          = 1'b1;
        bus.charReq    = 1'b0;
        bus.charIdx    = '0;
        bus.lineReq    = 1'b0;
        bus.lineIn     = '0;
        bus.nextLineIn = '0;
        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("rst");
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // 1: line refresh latency, hold and busy duration
        bus.lineReq    = 1'b1;
        bus.lineIn     = 64'h747970696e670000;
        bus.nextLineIn = 64'h0123456789abcdef;
        push_line(64'h747970696e670000, 64'h0123456789abcdef);
        tick();
        bus.lineReq    = 1'b0;
        bus.lineIn     = 64'hdeadbeefdeadbeef;
        bus.nextLineIn = 64'h1111111111111111;
        @(negedge clk);
        chk("t1_no_early", bus.wLineEn, 0);
        tick();
        @(negedge clk);
        chk("t1_pulse", bus.wLineEn, 1);
        repeat (7) tick();
        @(negedge clk);
        chk("t1_busy_hold", bus.busy, 1);
        tick();
        @(negedge clk);
        chk("t1_busy_drop", bus.busy, 0);
        chk("t1_line_hold", bus.lineOut, 64'h747970696e670000);

        // 2: three chars, exact spacing
        pcyc.delete();
        tick();
        for (int i = 1; i <= 3; i++) begin
            bus.charReq = 1'b1;
            bus.charIdx = 4'(i);
            push_char(4'(i));
            tick();
        end
        bus.charReq = 1'b0;
        @(negedge clk);
        chk("t2_pending", bus.pending, 2);
        wait_idle(60);
        chk("t2_pending_end", bus.pending, 0);
        chk("t2_npulses", pcyc.size(), 3);
        if (pcyc.size() == 3) begin
            chk("t2_space01", pcyc[1] - pcyc[0], CHAR_GAP + 1);
            chk("t2_space12", pcyc[2] - pcyc[1], CHAR_GAP + 1);
        end

        // 3: overflow with six back-to-back requests
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.charReq = 1'b1;
            bus.charIdx = 4'(i);
            if (i < 5) push_char(4'(i));
            tick();
        end
        bus.charReq = 1'b0;
        @(negedge clk);
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_pending", bus.pending, 4);
        wait_idle(100);
        chk("t3_overflow_sticky", bus.overflow, 1);

        // 4: line request plus char request flushes three queued chars
        tick();
        push_char(4'd7);
        for (int i = 7; i <= 10; i++) begin
            bus.charReq = 1'b1;
            bus.charIdx = 4'(i);
            tick();
        end
        bus.charReq = 1'b0;
        @(negedge clk);
        chk("t4_pending3", bus.pending, 3);
        bus.charReq    = 1'b1;
        bus.charIdx    = 4'd11;
        bus.lineReq    = 1'b1;
        bus.lineIn     = 64'h4c494e4534343434;
        bus.nextLineIn = 64'h6e65787434343434;
        push_line(64'h4c494e4534343434, 64'h6e65787434343434);
        tick();
        bus.charReq = 1'b0;
        bus.lineReq = 1'b0;
        @(negedge clk);
        chk("t4_pending0", bus.pending, 0);
        chk("t4_busy", bus.busy, 1);
        wait_idle(60);

        // 5: two line requests during a wait, only the second is issued
        tick();
        bus.charReq = 1'b1;
        bus.charIdx = 4'd5;
        push_char(4'd5);
        tick();
        bus.charReq = 1'b0;
        tick();
        bus.lineReq    = 1'b1;
        bus.lineIn     = 64'haaaaaaaaaaaaaaaa;
        bus.nextLineIn = 64'hbbbbbbbbbbbbbbbb;
        tick();
        bus.lineIn     = 64'h5555555555555555;
        bus.nextLineIn = 64'h6666666666666666;
        push_line(64'h5555555555555555, 64'h6666666666666666);
        tick();
        bus.lineReq = 1'b0;
        wait_idle(60);

        // 6: reset during wait with two chars queued
        tick();
        push_char(4'd1);
        for (int i = 1; i <= 3; i++) begin
            bus.charReq = 1'b1;
            bus.charIdx = 4'(i);
            tick();
        end
        bus.charReq = 1'b0;
        @(negedge clk);
        chk("t6_pending2", bus.pending, 2);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk_all_zero("t6_rst");
        reset = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        chk("t6_quiet_busy", bus.busy, 0);

`ifdef LCD_SCHED_COALESCE_EN
        // Duplicate indices collapse into one queued entry
        tick();
        bus.charReq = 1'b1;
        bus.charIdx = 4'd9;
        push_char(4'd9);
        tick();
        bus.charReq = 1'b0;
        tick();
        bus.charReq = 1'b1;
        bus.charIdx = 4'd2;
        push_char(4'd2);
        repeat (3) tick();
        bus.charReq = 1'b0;
        @(negedge clk);
        chk("co_pending", bus.pending, 1);
        wait_idle(60);
`endif

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
